// File: rtl/axi_arb_pkg.sv
// Shared types and sizing helpers for the AXI read arbiter.
package axi_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational round-robin picker: first requester strictly after i_last, wrapping.
module axi_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Walk candidates in priority order; the first hit is latched by w_found.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_last) + k) % NUM_REQ);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && i_req[j] && (w_cand == IDX_W'(j))) begin
                    o_winner = w_cand;
                    w_found  = 1'b1;
                end
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/axi_rd_arbiter.sv
// N:1 AXI read-channel arbiter: round-robin AR grant with per-master outstanding
// limits, master index carried in the upper downstream ID bits to route R beats back.
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int  NUM_MASTERS     = 2,
    parameter int  ID_W            = 4,
    parameter int  ADDR_W          = 32,
    parameter int  DATA_W          = 32,
    parameter int  MAX_OUTSTANDING = 4,
    localparam int IDX_W           = idx_width(NUM_MASTERS),
    localparam int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic                                ACLK,
    input  logic                                ARESETn,
    input  logic [NUM_MASTERS-1:0]              s_arvalid,
    output logic [NUM_MASTERS-1:0]              s_arready,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  s_araddr,
    input  logic [NUM_MASTERS-1:0][ID_W-1:0]    s_arid,
    input  logic [NUM_MASTERS-1:0][7:0]         s_arlen,
    output logic [NUM_MASTERS-1:0]              s_rvalid,
    input  logic [NUM_MASTERS-1:0]              s_rready,
    output logic [NUM_MASTERS-1:0]              s_rlast,
    output logic [DATA_W-1:0]                   s_rdata,
    output logic [ID_W-1:0]                     s_rid,
    output logic [1:0]                          s_rresp,
    output logic                                m_arvalid,
    input  logic                                m_arready,
    output logic [ADDR_W-1:0]                   m_araddr,
    output logic [ID_W+IDX_W-1:0]               m_arid,
    output logic [7:0]                          m_arlen,
    input  logic                                m_rvalid,
    output logic                                m_rready,
    input  logic [DATA_W-1:0]                   m_rdata,
    input  logic [ID_W+IDX_W-1:0]               m_rid,
    input  logic [1:0]                          m_rresp,
    input  logic                                m_rlast,
    output logic                                rid_err
);

    arb_state_e                              r_state, w_state_nxt;
    logic [IDX_W-1:0]                        r_winner, r_last, w_pick;
    logic                                    w_any;
    logic [NUM_MASTERS-1:0]                  w_elig, w_inc, w_dec;
    logic [NUM_MASTERS-1:0][CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]                        w_idx;
    logic                                    w_mapped, w_cnt_zero, w_ar_hs, w_r_last_hs;

    // ---------------- AR arbitration ----------------
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++)
            w_elig[i] = s_arvalid[i] && (r_cnt[i] < CNT_W'(MAX_OUTSTANDING));
    end

    axi_rr_picker #(.NUM_REQ(NUM_MASTERS), .IDX_W(IDX_W)) u_picker (
        .i_req    (w_elig),
        .i_last   (r_last),
        .o_winner (w_pick),
        .o_any    (w_any)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        m_arvalid   = 1'b0;
        s_arready   = '0;
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = ST_GRANT;
            ST_GRANT: begin
                m_arvalid           = 1'b1;
                s_arready[r_winner] = m_arready;
                if (m_arready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_ar_hs  = m_arvalid && m_arready;
    assign m_araddr = s_araddr[r_winner];
    assign m_arlen  = s_arlen[r_winner];
    assign m_arid   = {r_winner, s_arid[r_winner]};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_winner <= '0;
            r_last   <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            if (r_state == ST_IDLE && w_any) r_winner <= w_pick;
            if (w_ar_hs)                     r_last   <= r_winner;
        end
    end

    // ---------------- R routing ----------------
    assign w_idx   = m_rid[ID_W+IDX_W-1:ID_W];
    assign s_rid   = m_rid[ID_W-1:0];
    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;

    // Unmapped indices keep m_rready high so the stray beat drains instead of stalling.
    always_comb begin
        s_rvalid   = '0;
        s_rlast    = '0;
        m_rready   = 1'b1;
        w_mapped   = 1'b0;
        w_cnt_zero = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_idx == IDX_W'(i)) begin
                s_rvalid[i] = m_rvalid;
                s_rlast[i]  = m_rlast;
                m_rready    = s_rready[i];
                w_mapped    = 1'b1;
                w_cnt_zero  = (r_cnt[i] == '0);
            end
        end
    end

    assign w_r_last_hs = m_rvalid && m_rready && m_rlast;
    assign rid_err     = ARESETn && m_rvalid && (!w_mapped || (w_r_last_hs && w_cnt_zero));

    // ---------------- outstanding counters ----------------
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_inc[i] = w_ar_hs && (r_winner == IDX_W'(i));
            w_dec[i] = w_r_last_hs && (w_idx == IDX_W'(i)) && (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: 2-master instance for AR/R behaviour, 3-master one for unmapped IDs.
module tb_axi_rd_arbiter;

    localparam int NM = 2, ID_W = 4, ADDR_W = 32, DATA_W = 32, MO = 4;
    localparam int NM3 = 3;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [NM-1:0]              s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [NM-1:0][ADDR_W-1:0]  s_araddr;
    logic [NM-1:0][ID_W-1:0]    s_arid;
    logic [NM-1:0][7:0]         s_arlen;
    logic [DATA_W-1:0]          s_rdata;
    logic [ID_W-1:0]            s_rid;
    logic [1:0]                 s_rresp;
    logic                       m_arvalid, m_arready;
    logic [ADDR_W-1:0]          m_araddr;
    logic [ID_W:0]              m_arid;
    logic [7:0]                 m_arlen;
    logic                       m_rvalid, m_rready, m_rlast;
    logic [DATA_W-1:0]          m_rdata;
    logic [ID_W:0]              m_rid;
    logic [1:0]                 m_rresp;
    logic                       rid_err;

    logic [NM3-1:0]              s_arvalid3, s_arready3, s_rvalid3, s_rready3, s_rlast3;
    logic [NM3-1:0][ADDR_W-1:0]  s_araddr3;
    logic [NM3-1:0][ID_W-1:0]    s_arid3;
    logic [NM3-1:0][7:0]         s_arlen3;
    logic [DATA_W-1:0]           s_rdata3;
    logic [ID_W-1:0]             s_rid3;
    logic [1:0]                  s_rresp3;
    logic                        m_arvalid3, m_arready3;
    logic [ADDR_W-1:0]           m_araddr3;
    logic [ID_W+1:0]             m_arid3;
    logic [7:0]                  m_arlen3;
    logic                        m_rvalid3, m_rready3, m_rlast3;
    logic [ID_W+1:0]             m_rid3;
    logic                        rid_err3;

    axi_rd_arbiter #(.NUM_MASTERS(NM), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .MAX_OUTSTANDING(MO)) u_dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast),
        .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast), .rid_err(rid_err)
    );

    axi_rd_arbiter #(.NUM_MASTERS(NM3), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .MAX_OUTSTANDING(MO)) u_dut3 (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_arvalid(s_arvalid3), .s_arready(s_arready3), .s_araddr(s_araddr3), .s_arid(s_arid3),
        .s_arlen(s_arlen3), .s_rvalid(s_rvalid3), .s_rready(s_rready3), .s_rlast(s_rlast3),
        .s_rdata(s_rdata3), .s_rid(s_rid3), .s_rresp(s_rresp3),
        .m_arvalid(m_arvalid3), .m_arready(m_arready3), .m_araddr(m_araddr3), .m_arid(m_arid3),
        .m_arlen(m_arlen3), .m_rvalid(m_rvalid3), .m_rready(m_rready3), .m_rdata(m_rdata),
        .m_rid(m_rid3), .m_rresp(m_rresp), .m_rlast(m_rlast3), .rid_err(rid_err3)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs();
        s_arvalid = '0;  m_arready = 1'b0;  s_rready = '0;
        m_rvalid  = 1'b0; m_rlast  = 1'b0;  m_rid    = '0;
        m_rdata   = 32'hCAFE_0000;          m_rresp  = 2'b00;
        s_araddr[0] = 32'h0000_1000; s_araddr[1] = 32'h0000_2000;
        s_arlen[0]  = 8'h03;         s_arlen[1]  = 8'h07;
        s_arid[0]   = 4'h1;          s_arid[1]   = 4'h3;
        s_arvalid3 = '0; s_araddr3 = '0; s_arid3 = '0; s_arlen3 = '0; s_rready3 = '0;
        m_arready3 = 1'b0; m_rvalid3 = 1'b0; m_rid3 = '0; m_rlast3 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        ARESETn = 1'b0;
        repeat (2) tick();
        ARESETn = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state; an R beat that would otherwise flag a 0-count decrement must stay quiet.
        idle_inputs();
        m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 2'b11;
        #1;
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_rid_err", rid_err, 0);
        do_reset();

        // Round-robin 0,1,0,1 with both masters requesting.
        s_arvalid = 2'b11; m_arready = 1'b1;
        #1;
        chk("rr_idle0", m_arvalid, 0);
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("rr_valid", m_arvalid, 1);
            chk("rr_arid", m_arid, (g % 2) ? 5'h13 : 5'h01);
            chk("rr_arready", s_arready, (g % 2) ? 2'b10 : 2'b01);
            chk("rr_araddr", m_araddr, (g % 2) ? 32'h2000 : 32'h1000);
            chk("rr_arlen", m_arlen, (g % 2) ? 8'h07 : 8'h03);
            tick();
            chk("rr_gap", m_arvalid, 0);
        end
        s_arvalid = '0;

        // GRANT held under m_arready backpressure; no re-arbitration when master 0 joins.
        do_reset();
        s_arvalid = 2'b10; m_arready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", m_arvalid, 1);
            chk("hold_arid", m_arid, 5'h13);
            chk("hold_arready", s_arready, 2'b00);
            if (c == 1) s_arvalid = 2'b11;
            tick();
        end
        m_arready = 1'b1;
        #1;
        chk("hold_hs_ready", s_arready, 2'b10);
        tick();
        s_arvalid = '0;
        #1;
        chk("hold_done", m_arvalid, 0);

        // Master 0 fills its outstanding budget; an rlast beat frees one slot.
        do_reset();
        s_arvalid = 2'b01; m_arready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("blk_grant", m_arid, 5'h01);
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("blk_stall", m_arvalid, 0);
        end
        m_rvalid = 1'b1; m_rid = 5'h05; m_rlast = 1'b1; s_rready = 2'b01;
        #1;
        chk("blk_r_svalid", s_rvalid, 2'b01);
        chk("blk_r_mready", m_rready, 1);
        chk("blk_r_rid", s_rid, 4'h5);
        chk("blk_r_rlast", s_rlast, 2'b01);
        chk("blk_r_rdata", s_rdata, 32'hCAFE_0000);
        chk("blk_r_err", rid_err, 0);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;
        #1;
        chk("blk_idle", m_arvalid, 0);
        tick();
        chk("blk_regrant", m_arvalid, 1);
        tick();
        s_arvalid = '0;

        // R backpressure on master 1; only the rlast beat releases a slot.
        do_reset();
        s_arvalid = 2'b10; m_arready = 1'b1;
        repeat (8) tick();
        tick();
        chk("bp_full", m_arvalid, 0);
        m_rvalid = 1'b1; m_rid = 5'h12; m_rlast = 1'b0; s_rready = 2'b00;
        #1;
        chk("bp_mready_lo", m_rready, 0);
        chk("bp_svalid", s_rvalid, 2'b10);
        chk("bp_srid", s_rid, 4'h2);
        tick();
        s_rready = 2'b10;
        #1;
        chk("bp_mready_hi", m_rready, 1);
        tick();
        chk("bp_nolast0", m_arvalid, 0);
        tick();
        chk("bp_nolast1", m_arvalid, 0);
        m_rlast = 1'b1;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        tick();
        chk("bp_regrant", m_arvalid, 1);
        chk("bp_regrant_id", m_arid, 5'h13);
        tick();
        s_arvalid = '0;

        // rlast for master 0 with nothing open: dropped decrement flags rid_err.
        m_rvalid = 1'b1; m_rid = 5'h00; m_rlast = 1'b1; s_rready = 2'b01;
        #1;
        chk("zero_dec_err", rid_err, 1);
        chk("zero_dec_svalid", s_rvalid, 2'b01);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;

        // Reset during GRANT with master 1 holding two bursts.
        do_reset();
        s_arvalid = 2'b10; m_arready = 1'b1;
        repeat (4) tick();
        m_arready = 1'b0;
        tick();
        chk("mid_grant", m_arvalid, 1);
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_valid", m_arvalid, 0);
        chk("mid_rst_ready", s_arready, 2'b00);
        tick();
        tick();
        s_arvalid = 2'b11; m_arready = 1'b1;
        ARESETn = 1'b1;
        #1;
        chk("post_rst_idle", m_arvalid, 0);
        tick();
        chk("post_rst_first", m_arid, 5'h01);
        tick();
        s_arvalid = '0;
        m_rvalid = 1'b1; m_rid = 5'h10; m_rlast = 1'b1; s_rready = 2'b10;
        #1;
        chk("post_rst_cnt1", rid_err, 1);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;

        // Three-master instance: index 3 is unmapped, index 2 is routed.
        m_rvalid3 = 1'b1; m_rid3 = 6'h35; m_rlast3 = 1'b1; s_rready3 = 3'b000;
        #1;
        chk("unmap_err", rid_err3, 1);
        chk("unmap_mready", m_rready3, 1);
        chk("unmap_svalid", s_rvalid3, 3'b000);
        m_rid3 = 6'h25;
        #1;
        chk("map2_err", rid_err3, 0);
        chk("map2_svalid", s_rvalid3, 3'b100);
        chk("map2_mready", m_rready3, 0);
        m_rvalid3 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
